regfile_sequencer: RTL and testbench

Multicycle operand-fetch / writeback controller that drives the CPU register file as its sole initiator. It decodes one instruction at a time and issues a read cycle to the register file, then captures the operands. It hands them to the ALU over a valid/ready handshake, waits for the result, and issues the write cycle. It sits between instruction fetch and the `Registers` block plus ALU in the multicycle datapath.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/regfile_sequencer_if.sv | 49 ++++
 rtl/instr_field_decode.sv | 32 +++
 rtl/regfile_sequencer.sv | 127 ++++++++++++
 tb/tb_regfile_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field layout and
// the register-file sequencer state type.
package cpu_pkg;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned OPCODE_W   = 6;
   localparam int unsigned FUNCT_W    = 6;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned IMM_W      = 16;

   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned RS_LSB     = 21;
   localparam int unsigned RT_LSB     = 16;
   localparam int unsigned RD_LSB     = 11;
   localparam int unsigned IMM_LSB    = 0;
   localparam int unsigned FUNCT_LSB  = 0;

   localparam logic [OPCODE_W-1:0] OP_RTYPE     = 6'd0;
   localparam logic [OPCODE_W-1:0] OP_RF_NOP    = 6'd2;
   localparam logic [OPCODE_W-1:0] OP_ITYPE_MIN = 6'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_CAPTURE  = 3'd2,
      ST_EXEC     = 3'd3,
      ST_WAIT_RES = 3'd4,
      ST_WRITE    = 3'd5
   } rfseq_state_t;

   // Opcodes 1..3 retire without touching the register file or the ALU.
   function automatic logic is_nop_opcode(input logic [OPCODE_W-1:0] op);
      return (op != OP_RTYPE) && (op < OP_ITYPE_MIN);
   endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Bundle of the sequencer's instruction, register-file, ALU operand and
// ALU result connections.
interface regfile_sequencer_if import cpu_pkg::*; #(
   parameter int unsigned WORD_SIZE = 32
);

   logic                  instr_valid;
   logic                  instr_ready;
   logic [INSTR_W-1:0]    instr;

   logic [OPCODE_W-1:0]   rf_opcode;
   logic                  rf_regwrite;
   logic [REG_ADDR_W-1:0] rf_read_reg1;
   logic [REG_ADDR_W-1:0] rf_read_reg2;
   logic [REG_ADDR_W-1:0] rf_write_reg;
   logic [WORD_SIZE-1:0]  rf_write_data;
   logic [WORD_SIZE-1:0]  rf_read_data1;
   logic [WORD_SIZE-1:0]  rf_read_data2;

   logic                  op_valid;
   logic                  op_ready;
   logic [WORD_SIZE-1:0]  op_a;
   logic [WORD_SIZE-1:0]  op_b;
   logic [OPCODE_W-1:0]   op_opcode;
   logic [FUNCT_W-1:0]    op_funct;

   logic                  res_valid;
   logic                  res_ready;
   logic [WORD_SIZE-1:0]  res_data;

   logic                  wb_done;

   modport master (
      input  instr_valid, instr, rf_read_data1, rf_read_data2,
             op_ready, res_valid, res_data,
      output instr_ready, rf_opcode, rf_regwrite, rf_read_reg1, rf_read_reg2,
             rf_write_reg, rf_write_data, op_valid, op_a, op_b, op_opcode,
             op_funct, res_ready, wb_done
   );

   modport slave (
      output instr_valid, instr, rf_read_data1, rf_read_data2,
             op_ready, res_valid, res_data,
      input  instr_ready, rf_opcode, rf_regwrite, rf_read_reg1, rf_read_reg2,
             rf_write_reg, rf_write_data, op_valid, op_a, op_b, op_opcode,
             op_funct, res_ready, wb_done
   );

endinterface

// File: rtl/instr_field_decode.sv
// Combinational instruction decode: fields, class, destination register and
// sign-extended immediate.
module instr_field_decode import cpu_pkg::*; #(
   parameter int unsigned WORD_SIZE = 32
) (
   input  logic [INSTR_W-1:0]    instr,
   output logic [OPCODE_W-1:0]   opcode,
   output logic [FUNCT_W-1:0]    funct,
   output logic [REG_ADDR_W-1:0] rs,
   output logic [REG_ADDR_W-1:0] rt,
   output logic [REG_ADDR_W-1:0] dest,
   output logic                  is_rtype,
   output logic                  is_nop,
   output logic [WORD_SIZE-1:0]  imm_sext
);

   logic [REG_ADDR_W-1:0] rd;
   logic [IMM_W-1:0]      imm;

   assign opcode   = instr[OPCODE_LSB +: OPCODE_W];
   assign rs       = instr[RS_LSB +: REG_ADDR_W];
   assign rt       = instr[RT_LSB +: REG_ADDR_W];
   assign rd       = instr[RD_LSB +: REG_ADDR_W];
   assign imm      = instr[IMM_LSB +: IMM_W];
   assign funct    = instr[FUNCT_LSB +: FUNCT_W];

   assign is_rtype = (opcode == OP_RTYPE);
   assign is_nop   = is_nop_opcode(opcode);
   assign dest     = is_rtype ? rd : rt;
   assign imm_sext = {{(WORD_SIZE - IMM_W){imm[IMM_W-1]}}, imm};

endmodule

// File: rtl/regfile_sequencer.sv
// Multicycle operand-fetch / writeback controller: reads operands from the
// register file, hands them to the ALU, and writes the result back.
module regfile_sequencer import cpu_pkg::*; #(
   parameter int unsigned WORD_SIZE = 32
) (
   input logic                 clk,
   input logic                 rst,
   regfile_sequencer_if.master bus
);

   rfseq_state_t          state;
   rfseq_state_t          state_next;
   logic [INSTR_W-1:0]    instr_q;
   logic [INSTR_W-1:0]    dec_src;
   logic [OPCODE_W-1:0]   dec_opcode;
   logic [FUNCT_W-1:0]    dec_funct;
   logic [REG_ADDR_W-1:0] dec_rs;
   logic [REG_ADDR_W-1:0] dec_rt;
   logic [REG_ADDR_W-1:0] dec_dest;
   logic                  dec_rtype;
   logic                  dec_nop;
   logic [WORD_SIZE-1:0]  dec_imm;
   logic                  accept;
   logic                  wb_done_next;

   // In IDLE decode the offered word so READ outputs can be loaded on accept.
   assign dec_src = (state == ST_IDLE) ? bus.instr : instr_q;

   instr_field_decode #(.WORD_SIZE(WORD_SIZE)) u_decode (
      .instr    (dec_src),
      .opcode   (dec_opcode),
      .funct    (dec_funct),
      .rs       (dec_rs),
      .rt       (dec_rt),
      .dest     (dec_dest),
      .is_rtype (dec_rtype),
      .is_nop   (dec_nop),
      .imm_sext (dec_imm)
   );

   assign accept = bus.instr_valid & bus.instr_ready;

   always_comb begin
      state_next   = state;
      wb_done_next = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (dec_nop) wb_done_next = 1'b1;
               else         state_next   = ST_READ;
            end
         end
         ST_READ:    state_next = ST_CAPTURE;
         ST_CAPTURE: state_next = ST_EXEC;
         ST_EXEC: begin
            if (bus.op_ready) state_next = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            if (bus.res_valid) begin
               if (dec_dest == '0) begin
                  state_next   = ST_IDLE;
                  wb_done_next = 1'b1;
               end else begin
                  state_next   = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            state_next   = ST_IDLE;
            wb_done_next = 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Registered outputs are loaded from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q           <= '0;
         bus.instr_ready   <= 1'b1;
         bus.rf_opcode     <= OP_RF_NOP;
         bus.rf_read_reg1  <= '0;
         bus.rf_read_reg2  <= '0;
         bus.rf_write_reg  <= '0;
         bus.rf_write_data <= '0;
         bus.op_valid      <= 1'b0;
         bus.op_a          <= '0;
         bus.op_b          <= '0;
         bus.op_opcode     <= '0;
         bus.op_funct      <= '0;
         bus.res_ready     <= 1'b0;
         bus.wb_done       <= 1'b0;
      end else begin
         bus.instr_ready <= (state_next == ST_IDLE);
         bus.op_valid    <= (state_next == ST_EXEC);
         bus.res_ready   <= (state_next == ST_WAIT_RES);
         bus.wb_done     <= wb_done_next;
         bus.rf_opcode   <= (state_next == ST_READ || state_next == ST_WRITE) ?
                            dec_opcode : OP_RF_NOP;
         if (accept) instr_q <= bus.instr;
         if (state_next == ST_READ) begin
            bus.rf_read_reg1 <= dec_rs;
            bus.rf_read_reg2 <= dec_rtype ? dec_rt : '0;
         end
         // Read data is only valid for this one cycle, so it must be captured here.
         if (state == ST_CAPTURE) begin
            bus.op_a      <= bus.rf_read_data1;
            bus.op_b      <= dec_rtype ? bus.rf_read_data2 : dec_imm;
            bus.op_opcode <= dec_opcode;
            bus.op_funct  <= dec_funct;
         end
         if (state_next == ST_WRITE) begin
            bus.rf_write_reg  <= dec_dest;
            bus.rf_write_data <= bus.res_data;
         end
      end
   end

   // Reset in a WRITE cycle must not let the write reach the register file.
   assign bus.rf_regwrite = (state == ST_WRITE) & ~rst;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: register-file model, scripted ALU and
// a per-cycle checker driven by the expected phase schedule of each instruction.
module tb_regfile_sequencer;

   logic clk = 1'b0;
   logic rst;

   regfile_sequencer_if #(.WORD_SIZE(32)) bus ();

   regfile_sequencer #(.WORD_SIZE(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int wr_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Register file model: reads on a read edge, zeroes read data otherwise.
   logic [31:0] regs [32];
   logic [31:0] rd1 = '0;
   logic [31:0] rd2 = '0;
   logic        preload;

   assign bus.rf_read_data1 = rd1;
   assign bus.rf_read_data2 = rd2;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'(256 + i);
         regs[0] <= 32'd0;
         regs[1] <= 32'd5;
         regs[2] <= 32'd7;
      end
      if (bus.rf_regwrite) begin
         if (bus.rf_write_reg != 5'd0) regs[bus.rf_write_reg] <= bus.rf_write_data;
         wr_cnt <= wr_cnt + 1;
         rd1 <= '0;
         rd2 <= '0;
      end else if (bus.rf_opcode != 6'd2) begin
         rd1 <= regs[bus.rf_read_reg1];
         rd2 <= regs[bus.rf_read_reg2];
      end else begin
         rd1 <= '0;
         rd2 <= '0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", nm, cyc, act, exp);
      end
   endtask

   // Cycle (relative to accept) in which wb_done must pulse.
   function automatic int done_rel(input logic [31:0] ins, input int s1, input int s2);
      logic [5:0] opc;
      logic [4:0] dest;
      opc  = ins[31:26];
      dest = (opc == 6'd0) ? ins[15:11] : ins[20:16];
      if (opc >= 6'd1 && opc <= 6'd3) return 1;
      return (dest == 5'd0) ? 5 + s1 + s2 : 6 + s1 + s2;
   endfunction

   logic [31:0] m_ins, m_a, m_b;
   bit          m_active = 1'b0;
   bit          m_post_rst;
   int          m_acc, m_s1, m_s2, m_rst_at, m_end;
   int          last_done;

   always @(negedge clk) begin
      if (m_active) begin : cmp
         int         rel, xlo, xhi, wlo, whi, wr, done;
         logic [5:0] opc;
         logic [4:0] dest;
         logic       nop, rtype, busy, exp_opv;
         rel   = cyc - m_acc;
         opc   = m_ins[31:26];
         nop   = (opc >= 6'd1 && opc <= 6'd3);
         rtype = (opc == 6'd0);
         dest  = rtype ? m_ins[15:11] : m_ins[20:16];
         xlo   = 3;
         xhi   = 3 + m_s1;
         wlo   = xhi + 1;
         whi   = wlo + m_s2;
         done  = done_rel(m_ins, m_s1, m_s2);
         wr    = (nop || dest == 5'd0) ? -1 : whi + 1;
         if (rel <= m_end) begin
            busy    = !nop && rel >= 1 && rel < done;
            exp_opv = !nop && rel >= xlo && rel <= xhi;
            chk("instr_ready", 32'(bus.instr_ready), 32'(!busy));
            chk("rf_opcode", 32'(bus.rf_opcode),
                (!nop && (rel == 1 || rel == wr)) ? 32'(opc) : 32'd2);
            chk("rf_regwrite", 32'(bus.rf_regwrite), 32'(rel == wr && rel != m_rst_at));
            chk("op_valid", 32'(bus.op_valid), 32'(exp_opv));
            chk("res_ready", 32'(bus.res_ready), 32'(!nop && rel >= wlo && rel <= whi));
            chk("wb_done", 32'(bus.wb_done), 32'(rel == done));
            if (bus.wb_done) last_done = rel;
            if (!nop && rel == 1) begin
               chk("read_reg1", 32'(bus.rf_read_reg1), 32'(m_ins[25:21]));
               chk("read_reg2", 32'(bus.rf_read_reg2), rtype ? 32'(m_ins[20:16]) : 32'd0);
            end
            if (exp_opv) begin
               chk("op_a", bus.op_a, m_a);
               chk("op_b", bus.op_b, m_b);
               chk("op_opcode", 32'(bus.op_opcode), 32'(opc));
               chk("op_funct", 32'(bus.op_funct), 32'(m_ins[5:0]));
            end
            if (rel == wr) begin
               chk("write_reg", 32'(bus.rf_write_reg), 32'(dest));
               chk("write_data", bus.rf_write_data, m_a + m_b);
            end
            if (rel == 0 && m_post_rst) begin
               chk("rst_op_a", bus.op_a, 32'd0);
               chk("rst_op_b", bus.op_b, 32'd0);
               chk("rst_op_opcode", 32'(bus.op_opcode), 32'd0);
               chk("rst_op_funct", 32'(bus.op_funct), 32'd0);
               chk("rst_read_reg1", 32'(bus.rf_read_reg1), 32'd0);
               chk("rst_read_reg2", 32'(bus.rf_read_reg2), 32'd0);
               chk("rst_write_reg", 32'(bus.rf_write_reg), 32'd0);
               chk("rst_write_data", bus.rf_write_data, 32'd0);
            end
         end
      end
   end

   // Offer one instruction at c0 and script the ALU; rst_at >= 0 pulses reset in that cycle.
   task automatic run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input int s1, input int s2, input int rst_at, input bit stray,
                      input bit post_rst);
      int xhi, whi, stop;
      xhi  = 3 + s1;
      whi  = xhi + 1 + s2;
      stop = (rst_at >= 0) ? rst_at : done_rel(ins, s1, s2);
      m_ins = ins; m_a = a; m_b = b; m_s1 = s1; m_s2 = s2;
      m_rst_at = rst_at; m_end = stop; m_post_rst = post_rst;
      m_acc = cyc; last_done = -1; m_active = 1'b1;
      bus.instr = ins;
      for (int k = 0; k <= stop; k++) begin
         bus.instr_valid = (k == 0);
         rst             = (k == rst_at);
         bus.op_ready    = (k == xhi);
         bus.res_valid   = (k == whi) || (stray && (k == 2 || k == 3));
         bus.res_data    = (k == whi) ? a + b : 32'hDEAD_BEEF;
         @(posedge clk);
         #1;
      end
      m_active        = 1'b0;
      bus.instr_valid = 1'b0;
      bus.op_ready    = 1'b0;
      bus.res_valid   = 1'b0;
      rst             = 1'b0;
   endtask

   int n;

   initial begin
      rst = 1'b1;
      preload = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.op_ready    = 1'b0;
      bus.res_valid   = 1'b0;
      bus.res_data    = '0;
      repeat (2) @(posedge clk);
      #1 preload = 1'b0;
      @(negedge clk);
      chk("reset_instr_ready", 32'(bus.instr_ready), 32'd1);
      chk("reset_rf_opcode", 32'(bus.rf_opcode), 32'd2);
      chk("reset_rf_regwrite", 32'(bus.rf_regwrite), 32'd0);
      chk("reset_op_valid", 32'(bus.op_valid), 32'd0);
      chk("reset_res_ready", 32'(bus.res_ready), 32'd0);
      chk("reset_wb_done", 32'(bus.wb_done), 32'd0);
      chk("reset_op_a", bus.op_a, 32'd0);
      chk("reset_write_data", bus.rf_write_data, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // add $3,$1,$2
      run(32'h00221820, 32'd5, 32'd7, 0, 0, -1, 1'b0, 1'b1);
      chk("add_done_cycle", 32'(last_done), 32'd6);
      chk("add_result_r3", regs[3], 32'd12);

      // addi $4,$1,-3
      run(32'h2024FFFD, 32'd5, 32'hFFFF_FFFD, 0, 0, -1, 1'b0, 1'b0);
      chk("addi_done_cycle", 32'(last_done), 32'd6);
      chk("addi_result_r4", regs[4], 32'd2);

      // jump: no register file or ALU activity
      n = wr_cnt;
      run(32'h08000010, 32'd0, 32'd0, 0, 0, -1, 1'b0, 1'b0);
      chk("j_done_cycle", 32'(last_done), 32'd1);
      chk("j_no_write", 32'(wr_cnt), 32'(n));

      // add $0,$1,$2: write skipped
      n = wr_cnt;
      run(32'h00220020, 32'd5, 32'd7, 0, 0, -1, 1'b0, 1'b0);
      chk("rd0_done_cycle", 32'(last_done), 32'd5);
      chk("rd0_no_write", 32'(wr_cnt), 32'(n));

      // add $5,$3,$4 with op_ready stalled 3 and res_valid delayed 2, stray early res_valid
      run(32'h00642820, 32'd12, 32'd2, 3, 2, -1, 1'b1, 1'b0);
      chk("stall_done_cycle", 32'(last_done), 32'd11);
      chk("stall_result_r5", regs[5], 32'd14);

      // add $6,$1,$2 reset in WAIT_RES, then addi $7,$2,5 right after
      n = wr_cnt;
      run(32'h00223020, 32'd5, 32'd7, 0, 2, 5, 1'b0, 1'b0);
      chk("rst_wait_no_done", 32'(last_done), 32'hFFFF_FFFF);
      run(32'h20470005, 32'd7, 32'd5, 0, 0, -1, 1'b0, 1'b1);
      chk("post_rst_result_r7", regs[7], 32'd12);
      chk("rst_wait_r6_kept", regs[6], 32'h106);
      chk("rst_wait_write_count", 32'(wr_cnt), 32'(n + 1));

      // add $8,$1,$2 reset in WRITE, then opcode-3 instruction right after
      n = wr_cnt;
      run(32'h00224020, 32'd5, 32'd7, 0, 0, 5, 1'b0, 1'b0);
      run(32'h0C000001, 32'd0, 32'd0, 0, 0, -1, 1'b0, 1'b1);
      chk("op3_done_cycle", 32'(last_done), 32'd1);
      chk("rst_write_r8_kept", regs[8], 32'h108);
      chk("rst_write_no_write", 32'(wr_cnt), 32'(n));

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
